timer_counter: RTL and testbench
================================

// Module: timer_counter
// PURPOSE
//  8-bit up/down timer counter with a power-of-two clock prescaler and parallel load from the TDR.
//  Sits directly upstream of the ovf/udf compare stage and feeds it cnt and last_cnt.
//  last_cnt is the previous pclk cycle's cnt, so every counter transition (ff->00 or 00->ff)
//  is visible to the compare stage for exactly one pclk cycle, whatever the prescale ratio.
// PARAMETERS
//  CNT_W  8  counter width (compare stage requires 8)
//  PSC_W  7  prescaler width; maximum divide = 2**PSC_W
// PORTS
//  pclk      in   1      clock
//  preset_n  in   1      reset, asynchronous, active-low
//  en        in   1      count enable (TCR.en)
//  updw      in   1      0 = count up, 1 = count down
//  load      in   1      level; 1 = hold counter at tdr
//  tdr       in   CNT_W  load value
//  cks       in   3      prescale select; divide = 2**cks (1..128)
//  dbg_halt  in   1      debug freeze (present only with TIMER_CNT_HALT_EN)
//  cnt       out  CNT_W  current count
//  last_cnt  out  CNT_W  cnt delayed one pclk
//  tick      out  1      1-cycle count strobe (registered)
// BEHAVIOUR
//  - Reset: cnt=0, last_cnt=0, tick=0, prescaler psc=0.
//  - last_cnt <= cnt on every pclk edge, unconditionally, except during load (see below).
//  - Prescaler: PSC_W-bit psc; increments by 1 per pclk while en=1 and load=0; it wraps naturally.
//  - tick_c = en & !load & (cks==0 | psc[cks-1:0] all ones). tick <= tick_c, so tick is
//    aligned with the cycle in which cnt shows its new value.
//  - Count: on tick_c, cnt <= cnt+1 (updw=0) or cnt-1 (updw=1), modulo 2**CNT_W.
//    Wrap: up ff->00, down 00->ff. The counter never saturates.
//  - Rate: cks=0 gives a step every pclk. cks=n gives a step every 2**n pclk.
//    The first step after reset or load comes 2**n cycles after en=1.
//  - Load (priority over counting): while load=1, cnt <= tdr, last_cnt <= tdr, psc <= 0, tick <= 0.
//    This means no false ff->00 or 00->ff pair is presented to the compare stage on release.
//    Counting resumes on the first cycle with load=0.
//  - en=0: cnt and psc hold. tick=0. last_cnt converges to cnt one cycle later.
//    Re-asserting en resumes with the prescaler phase preserved.
//  - Changing cks mid-run takes effect on the next cycle, using the current psc bits. psc is not cleared.
//  - Changing updw mid-run: the next step uses the new direction. No extra step or skipped step.
//  - Asynchronous reset mid-count returns all state to the reset values immediately.
// CONFIGURATION
//  TIMER_CNT_HALT_EN defined: the dbg_halt port exists.
//    While dbg_halt=1, cnt, psc and last_cnt freeze and tick=0. load is ignored.
//    On release, operation continues from the frozen state.
//  Undefined: the dbg_halt port is absent. The counter behaves as if dbg_halt=0.
// TESTING
//  1. Assert reset mid-count (cnt=0x37) -> cnt=0, last_cnt=0, tick=0 before the next edge.
//  2. load=1 with tdr=0xfe, release, en=1, updw=0, cks=0 -> cnt: fe, ff, 00, 01.
//     Exactly one cycle has last_cnt=ff and cnt=00. tick is high each cycle.
//  3. tdr=0x01, updw=1, cks=0 -> cnt: 01, 00, ff. Exactly one cycle has last_cnt=00 and cnt=ff.
//  4. cks=2, en=1 from cnt=0x10 -> cnt steps every 4 pclk. tick is a 1-cycle pulse every 4 cycles.
//     Deassert en for 10 cycles -> cnt frozen. Re-enable -> the step spacing continues with psc phase kept.
//  5. cnt=0xff counting up; load=1 for one cycle with tdr=0x00 -> cnt=00 and last_cnt=00 on the same cycle.
//     No ff->00 pair appears. Counting resumes at 01.
//  6. TIMER_CNT_HALT_EN: dbg_halt=1 for 5 cycles at cnt=0x80 with cks=0 -> cnt=80, tick=0 throughout.
//     Release -> cnt=81 on the next cycle.

Source files
------------

// File: rtl/timer_counter.sv
// timer_counter: 8-bit up/down timer with 2**cks prescaler and TDR parallel load.
// Optional macro TIMER_CNT_HALT_EN adds the dbg_halt debug-freeze port.
module timer_counter #(
   parameter int CNT_W = 8,
   parameter int PSC_W = 7
) (
   input  logic             pclk,
   input  logic             preset_n,
   input  logic             en,
   input  logic             updw,
   input  logic             load,
   input  logic [CNT_W-1:0] tdr,
   input  logic [2:0]       cks,
`ifdef TIMER_CNT_HALT_EN
   input  logic             dbg_halt,
`endif
   output logic [CNT_W-1:0] cnt,
   output logic [CNT_W-1:0] last_cnt,
   output logic             tick
);
   logic [PSC_W-1:0] psc;
   logic [PSC_W-1:0] mask;
   logic             halt;
   logic             tick_c;
`ifdef TIMER_CNT_HALT_EN
   assign halt = dbg_halt;
`else
   assign halt = 1'b0;
`endif
   // low cks bits of the prescaler must all be ones; cks=0 gives an empty mask, so every cycle fires
   always_comb begin
      mask   = ~({PSC_W{1'b1}} << cks);
      tick_c = en & ~load & ~halt & ((psc & mask) == mask);
   end
   // halt freezes everything, load overrides counting and seeds last_cnt so no false wrap is seen
   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         cnt      <= '0;
         last_cnt <= '0;
         psc      <= '0;
         tick     <= 1'b0;
      end else if (halt) begin
         tick     <= 1'b0;
      end else if (load) begin
         cnt      <= tdr;
         last_cnt <= tdr;
         psc      <= '0;
         tick     <= 1'b0;
      end else begin
         last_cnt <= cnt;
         tick     <= tick_c;
         if (en) psc <= psc + PSC_W'(1);
         if (tick_c) cnt <= updw ? cnt - CNT_W'(1) : cnt + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: table vectors, hand sequences and randomized run against a behavioural model.
// Build with TIMER_CNT_HALT_EN defined to also exercise dbg_halt.
module tb_timer_counter;
   logic       pclk = 1'b0;
   logic       preset_n = 1'b0;
   logic       en = 1'b0;
   logic       updw = 1'b0;
   logic       load = 1'b0;
   logic [7:0] tdr = 8'h00;
   logic [2:0] cks = 3'd0;
   logic       dbg_halt = 1'b0;
   logic [7:0] cnt;
   logic [7:0] last_cnt;
   logic       tick;

   int n_cmp = 0;
   int n_err = 0;

   int m_cnt = 0;
   int m_last = 0;
   int m_psc = 0;
   int m_tick = 0;

   timer_counter dut (
      .pclk(pclk),
      .preset_n(preset_n),
      .en(en),
      .updw(updw),
      .load(load),
      .tdr(tdr),
      .cks(cks),
`ifdef TIMER_CNT_HALT_EN
      .dbg_halt(dbg_halt),
`endif
      .cnt(cnt),
      .last_cnt(last_cnt),
      .tick(tick)
   );

   always #5 pclk = ~pclk;

   typedef struct {
      logic       ld;
      logic [7:0] td;
      logic       e;
      logic       ud;
      logic [2:0] ck;
      logic [7:0] ec;
      logic [7:0] el;
      logic       et;
   } vec_t;

   vec_t vt[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // one clock of the specified behaviour, in plain arithmetic
   task automatic model_step();
      int p;
      int fire;
      logic hlt;
`ifdef TIMER_CNT_HALT_EN
      hlt = dbg_halt;
`else
      hlt = 1'b0;
`endif
      if (hlt) m_tick = 0;
      else if (load) begin
         m_cnt = int'(tdr); m_last = int'(tdr); m_psc = 0; m_tick = 0;
      end else begin
         p = 1 << cks;
         fire = (en && (m_psc % p == p - 1)) ? 1 : 0;
         m_last = m_cnt;
         m_tick = fire;
         if (en) m_psc = (m_psc + 1) % 128;
         if (fire != 0) m_cnt = updw ? (m_cnt + 255) % 256 : (m_cnt + 1) % 256;
      end
   endtask

   task automatic cycle(input bit check_model);
      model_step();
      @(posedge pclk);
      #1;
      if (check_model) begin
         chk("cnt", 32'(cnt), 32'(m_cnt));
         chk("last_cnt", 32'(last_cnt), 32'(m_last));
         chk("tick", 32'(tick), 32'(m_tick));
      end
   endtask

   task automatic drive(input logic l, input logic [7:0] t, input logic e, input logic u, input logic [2:0] c);
      load = l; tdr = t; en = e; updw = u; cks = c;
   endtask

   initial begin
      int wraps;
      int ticks;
      // up wrap (fe,ff,00,01), down wrap (01,00,ff), load at ff, en drop
      vt.push_back('{1'b1, 8'hfe, 1'b0, 1'b0, 3'd0, 8'hfe, 8'hfe, 1'b0});
      vt.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'hff, 8'hfe, 1'b1});
      vt.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 8'hff, 1'b1});
      vt.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h01, 8'h00, 1'b1});
      vt.push_back('{1'b1, 8'h01, 1'b1, 1'b1, 3'd0, 8'h01, 8'h01, 1'b0});
      vt.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 3'd0, 8'h00, 8'h01, 1'b1});
      vt.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 3'd0, 8'hff, 8'h00, 1'b1});
      vt.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 3'd0, 8'hfe, 8'hff, 1'b1});
      vt.push_back('{1'b1, 8'hfe, 1'b1, 1'b0, 3'd0, 8'hfe, 8'hfe, 1'b0});
      vt.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'hff, 8'hfe, 1'b1});
      vt.push_back('{1'b1, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0});
      vt.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h01, 8'h00, 1'b1});
      vt.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h02, 8'h01, 1'b1});
      vt.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h02, 8'h02, 1'b0});
      vt.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h02, 8'h02, 1'b0});

      #12;
      chk("reset_cnt", 32'(cnt), 32'h0);
      chk("reset_last", 32'(last_cnt), 32'h0);
      chk("reset_tick", 32'(tick), 32'h0);
      @(negedge pclk);
      preset_n = 1'b1;
      @(posedge pclk);
      #1;

      foreach (vt[i]) begin
         drive(vt[i].ld, vt[i].td, vt[i].e, vt[i].ud, vt[i].ck);
         cycle(1'b0);
         chk($sformatf("vec%0d_cnt", i), 32'(cnt), 32'(vt[i].ec));
         chk($sformatf("vec%0d_last", i), 32'(last_cnt), 32'(vt[i].el));
         chk($sformatf("vec%0d_tick", i), 32'(tick), 32'(vt[i].et));
      end

      // cks=2 from 0x10: step every 4 cycles, then an en gap that keeps the prescaler phase
      drive(1'b1, 8'h10, 1'b0, 1'b0, 3'd2);
      cycle(1'b1);
      drive(1'b0, 8'h00, 1'b1, 1'b0, 3'd2);
      ticks = 0;
      for (int i = 0; i < 6; i++) begin
         cycle(1'b1);
         ticks += int'(tick);
      end
      chk("psc4_cnt", 32'(cnt), 32'h11);
      chk("psc4_ticks", 32'(ticks), 32'd1);
      en = 1'b0;
      for (int i = 0; i < 10; i++) cycle(1'b1);
      chk("en_off_cnt", 32'(cnt), 32'h11);
      en = 1'b1;
      cycle(1'b1);
      chk("resume_hold", 32'(cnt), 32'h11);
      cycle(1'b1);
      chk("resume_step", 32'(cnt), 32'h12);
      for (int i = 0; i < 4; i++) cycle(1'b1);
      chk("resume_next", 32'(cnt), 32'h13);

      // asynchronous reset mid-count at 0x37
      drive(1'b1, 8'h36, 1'b1, 1'b0, 3'd0);
      cycle(1'b1);
      load = 1'b0;
      cycle(1'b1);
      chk("pre_reset_cnt", 32'(cnt), 32'h37);
      preset_n = 1'b0;
      #1;
      chk("areset_cnt", 32'(cnt), 32'h0);
      chk("areset_last", 32'(last_cnt), 32'h0);
      chk("areset_tick", 32'(tick), 32'h0);
      m_cnt = 0; m_last = 0; m_psc = 0; m_tick = 0;
      @(negedge pclk);
      preset_n = 1'b1;
      en = 1'b0;
      @(posedge pclk);
      #1;

`ifdef TIMER_CNT_HALT_EN
      drive(1'b1, 8'h7f, 1'b1, 1'b0, 3'd0);
      cycle(1'b1);
      load = 1'b0;
      cycle(1'b1);
      chk("halt_start", 32'(cnt), 32'h80);
      dbg_halt = 1'b1;
      load = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1);
         chk("halt_cnt", 32'(cnt), 32'h80);
         chk("halt_tick", 32'(tick), 32'h0);
      end
      dbg_halt = 1'b0;
      load = 1'b0;
      cycle(1'b1);
      chk("halt_release", 32'(cnt), 32'h81);
`endif

      // randomized run against the model, counting wrap pairs for coverage sanity
      wraps = 0;
      for (int i = 0; i < 3000; i++) begin
         load = ($urandom_range(0, 24) == 0);
         tdr = 8'($urandom);
         en = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 15) == 0) updw = ~updw;
         if ($urandom_range(0, 31) == 0) cks = 3'($urandom_range(0, 3));
`ifdef TIMER_CNT_HALT_EN
         dbg_halt = ($urandom_range(0, 19) == 0);
`endif
         cycle(1'b1);
         if ((last_cnt == 8'hff && cnt == 8'h00) || (last_cnt == 8'h00 && cnt == 8'hff)) wraps++;
      end
      $display("random run saw %0d wrap transitions", wraps);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
